raptor64_normalize: RTL
=======================

// Module: raptor64_normalize
// PURPOSE
//  Multi-cycle normalizer: the inverse of the shift unit. The shifter takes data
//  and a shift amount; this block takes data and finds the shift amount. It
//  left-shifts an operand until its leading bit is significant and returns both
//  the normalized value and the count (CLZ / CLS). Sits beside the ALU in EX and
//  is used for count-leading-zeros/sign ops and FP mantissa normalization. The
//  pipeline stalls while busy_o is high.
// PARAMETERS
//  STEP  8  coarse shift per cycle; legal values 2, 4, 8, 16 (data width fixed 64)
// PORTS
//  clk_i     in   1   clock
//  rst_i     in   1   asynchronous reset, active-high
//  ld_i      in   1   start request; sampled only in IDLE
//  signed_i  in   1   0 = count leading zeros; 1 = count redundant sign bits
//  a_i       in   64  operand, captured on the ld_i edge
//  busy_o    out  1   operation in progress (COARSE, FINE, DONE)
//  done_o    out  1   single-cycle result strobe
//  o         out  64  normalized value
//  cnt_o     out  7   shift count applied
//  zero_o    out  1   operand was zero
// BEHAVIOUR
//  - Reset, async and active-high: state = IDLE; busy_o, done_o, o, cnt_o and zero_o = 0.
//    Assertion mid-operation aborts immediately. No partial result is kept.
//  - States: IDLE, COARSE, FINE, DONE. One transition per clock.
//  - IDLE, ld_i=1: latch r = a_i, sgn = signed_i, cnt = 0.
//    - If a_i == 0: o = 0, zero_o = 1, cnt_o = 64 (unsigned) or 63 (signed), next = DONE.
//    - Otherwise: zero_o = 0, next = COARSE.
//  - IDLE, ld_i=0: hold o, cnt_o and zero_o from the last result.
//  - Coarse condition:
//    - unsigned: r[63:64-STEP] == 0.
//    - signed: r[63:63-STEP] are all equal (STEP+1 bits).
//  - Fine condition:
//    - unsigned: r[63] == 0.
//    - signed: r[63] == r[62].
//  - COARSE: if the coarse condition holds, r <<= STEP and cnt += STEP, stay in COARSE.
//    Otherwise go to FINE with no shift that cycle.
//  - FINE: if the fine condition holds, r <<= 1 and cnt += 1, stay in FINE.
//    Otherwise go to DONE.
//  - DONE: o = r, cnt_o = cnt, done_o = 1 for exactly this one cycle, then IDLE.
//  - Shifts fill with zeros. cnt never exceeds 63 on the non-zero path.
//  - The all-ones signed operand terminates at cnt = 63 with o = 64'h8000_0000_0000_0000.
//  - Latency, counting from the edge that samples ld_i to the cycle where done_o = 1:
//    - zero operand: 1 cycle.
//    - otherwise: 3 + n/STEP + n%STEP cycles, where n is the final count.
//  - busy_o = 1 in COARSE, FINE and DONE. It is never high in the same cycle that
//    ld_i is accepted.
//  - ld_i while busy_o = 1 is ignored, including ld_i during DONE. No queueing.
//  - a_i and signed_i changing after capture have no effect on the result.
//  - o, cnt_o and zero_o are registered and remain stable from DONE until the
//    next accepted ld_i.
// TESTING
//  - Reset: assert rst_i mid-COARSE (a_i = 1, unsigned).
//    -> busy_o, done_o, o and cnt_o drop to 0 asynchronously; the next ld works normally.
//  - Unsigned a_i = 64'h1.
//    -> done_o 17 cycles after ld; o = 64'h8000_0000_0000_0000, cnt_o = 63, zero_o = 0.
//  - Unsigned a_i = 64'h8000_0000_0000_0000.
//    -> done_o after 3 cycles; cnt_o = 0, o = a_i.
//  - Unsigned a_i = 0.
//    -> done_o after 1 cycle; zero_o = 1, cnt_o = 64, o = 0.
//  - Signed a_i = 64'hFFFF_FFFF_FFFF_F000 (n = 51).
//    -> done_o after 12 cycles; cnt_o = 51, o = 64'h8000_0000_0000_0000.
//  - Signed a_i = 64'hFFFF_FFFF_FFFF_FFFF.
//    -> cnt_o = 63, o = 64'h8000_0000_0000_0000.
//  - Pulse ld_i with a new operand in every busy cycle and on the DONE cycle.
//    -> first result unchanged; no extra done_o; back-to-back ld accepted the cycle after DONE.

Source files
------------

// File: rtl/raptor64_normalize.sv
// ---------------------------------------------------------------------------
// raptor64_normalize
//
// Multi-cycle normalizer. It is the inverse of the shift unit. The shifter is
// given data and a shift amount. This block is given data and finds the shift
// amount.
//
// It left-shifts a 64-bit operand until the leading bit is significant. It then
// returns the normalized value and the number of bit positions shifted:
//   - unsigned mode: count leading zeros.
//   - signed mode:   count redundant sign bits.
//
// The block sits beside the ALU in EX. The pipeline stalls while busy_o is high.
//
// The search runs in two phases:
//   1. COARSE jumps STEP bits per cycle while the top field is uninformative.
//   2. FINE finishes one bit per cycle.
//
// Parameters
//   STEP      coarse shift per cycle. Legal values are 2, 4, 8 and 16.
//
// Ports
//   clk_i     clock
//   rst_i     asynchronous reset, active-high; aborts any operation in flight
//   ld_i      start request, sampled only while idle
//   signed_i  0 = count leading zeros, 1 = count redundant sign bits
//   a_i       operand, captured on the edge that accepts ld_i
//   busy_o    high in COARSE, FINE and DONE
//   done_o    single-cycle result strobe (the DONE cycle)
//   o         normalized value (registered, held until the next accepted load)
//   cnt_o     shift count applied (registered, held)
//   zero_o    operand was zero (registered, held)
//   state_o   current FSM state: 0 IDLE, 1 COARSE, 2 FINE, 3 DONE
//
// Handshake
//   A load is accepted on a rising edge where state is IDLE and ld_i is high.
//   busy_o is low in that cycle.
//   A load presented while busy_o is high is dropped, not queued.
//   Exactly one done_o pulse follows every accepted load, unless reset
//   intervenes.
// ---------------------------------------------------------------------------
module raptor64_normalize #(
    parameter int STEP = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_i,
    input  logic        signed_i,
    input  logic [63:0] a_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] o,
    output logic [6:0]  cnt_o,
    output logic        zero_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] STEP_CNT = 7'(STEP);

    state_t      state;
    logic [63:0] r;      // working operand
    logic        sgn;    // captured mode
    logic [6:0]  cnt;    // running shift count

    // Top-of-operand fields examined by the coarse test.
    // The signed test needs one extra bit: the sign bit itself must also
    // match the STEP bits that would be shifted out.
    logic [STEP-1:0] top_u;
    logic [STEP:0]   top_s;
    logic            coarse_hit;
    logic            fine_hit;

    assign top_u = r[63 -: STEP];
    assign top_s = r[63 -: STEP+1];

    always_comb begin
        coarse_hit = 1'b0;
        fine_hit   = 1'b0;
        if (sgn) begin
            coarse_hit = (&top_s) | ~(|top_s);
            fine_hit   = (r[63] == r[62]);
        end else begin
            coarse_hit = ~(|top_u);
            fine_hit   = ~r[63];
        end
    end

    assign state_o = state;

    // A non-zero operand always has a significant bit. Both loops therefore
    // terminate, and cnt stays at or below 63.
    // The zero operand bypasses the search and reports the full width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            r      <= '0;
            sgn    <= 1'b0;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            o      <= '0;
            cnt_o  <= '0;
            zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_i) begin
                        r      <= a_i;
                        sgn    <= signed_i;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (a_i == 64'd0) begin
                            o      <= '0;
                            zero_o <= 1'b1;
                            cnt_o  <= signed_i ? 7'd63 : 7'd64;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            zero_o <= 1'b0;
                            state  <= COARSE;
                        end
                    end
                end

                COARSE: begin
                    if (coarse_hit) begin
                        r   <= r << STEP;
                        cnt <= cnt + STEP_CNT;
                    end else begin
                        // Hand over without shifting; FINE re-examines the same r.
                        state <= FINE;
                    end
                end

                FINE: begin
                    if (fine_hit) begin
                        r   <= r << 1;
                        cnt <= cnt + 7'd1;
                    end else begin
                        // Publish the result together with the strobe.
                        o      <= r;
                        cnt_o  <= cnt;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
